axilite_slave_resp: RTL and testbench

Parametrised AXI4-Lite slave bridging an AXI-Lite master to a simple start/done backend register interface. Unlike the posted-write-only generation, it implements the full write-response channel. AW and W are accepted independently and in either order. The B and R responses are held until the backend reports done, and a configurable backend timeout returns SLVERR. Read and write paths are independent and may be active concurrently.

---
 rtl/axilite_slave_resp.sv | 193 +++++++++++++++++++
 tb/tb_axilite_slave_resp.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_slave_resp.sv
// ==== axilite_slave_resp : AXI4-Lite slave with B/R responses over a start/done backend ====
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module axilite_slave_resp #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic [STRB_W-1:0]     axi_wstrb,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  bk_wstart,
  output logic [ADDR_WIDTH-1:0] bk_waddr,
  output logic [DATA_WIDTH-1:0] bk_wdata,
  output logic [STRB_W-1:0]     bk_wstrb,
  input  logic                  bk_wdone,
  output logic                  bk_rstart,
  output logic [ADDR_WIDTH-1:0] bk_raddr,
  input  logic [DATA_WIDTH-1:0] bk_rdata,
  input  logic                  bk_rdone
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_BK = 2'd1, WR_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_BK = 2'd1, RD_RESP = 2'd2} rd_state_t;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  aw_got;
  logic                  w_got;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [CNT_W-1:0]      wcnt;
  logic [CNT_W-1:0]      rcnt;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  aw_have;
  logic                  w_have;

  assign aw_hs   = axi_awvalid & axi_awready;
  assign w_hs    = axi_wvalid & axi_wready;
  assign ar_hs   = axi_arvalid & axi_arready;
  assign aw_have = aw_got | aw_hs;
  assign w_have  = w_got | w_hs;

  // Write path; a done is only meaningful once the start pulse has been seen by the backend.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wr_state    <= WR_IDLE;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wcnt        <= '0;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      bk_wstart   <= 1'b0;
      bk_waddr    <= '0;
      bk_wdata    <= '0;
      bk_wstrb    <= '0;
    end else begin
      bk_wstart <= 1'b0;
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            aw_got   <= 1'b1;
            awaddr_q <= axi_awaddr;
          end
          if (w_hs) begin
            w_got   <= 1'b1;
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
          end
          axi_awready <= !aw_have;
          axi_wready  <= !w_have;
          if (aw_have && w_have) begin
            wr_state  <= WR_BK;
            bk_wstart <= 1'b1;
            bk_waddr  <= aw_hs ? axi_awaddr : awaddr_q;
            bk_wdata  <= w_hs ? axi_wdata : wdata_q;
            bk_wstrb  <= w_hs ? axi_wstrb : wstrb_q;
            wcnt      <= '0;
          end
        end
        WR_BK: begin
          if (bk_wdone && !bk_wstart) begin
            wr_state   <= WR_RESP;
            axi_bvalid <= 1'b1;
            axi_bresp  <= RESP_OKAY;
          end else if (TO_EN && wcnt == TO_VAL) begin
            wr_state   <= WR_RESP;
            axi_bvalid <= 1'b1;
            axi_bresp  <= RESP_SLVERR;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        WR_RESP: begin
          if (axi_bready) begin
            wr_state    <= WR_IDLE;
            axi_bvalid  <= 1'b0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      rd_state    <= RD_IDLE;
      rcnt        <= '0;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
      bk_rstart   <= 1'b0;
      bk_raddr    <= '0;
    end else begin
      bk_rstart <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          axi_arready <= !ar_hs;
          if (ar_hs) begin
            rd_state  <= RD_BK;
            bk_rstart <= 1'b1;
            bk_raddr  <= axi_araddr;
            rcnt      <= '0;
          end
        end
        RD_BK: begin
          if (bk_rdone && !bk_rstart) begin
            rd_state   <= RD_RESP;
            axi_rvalid <= 1'b1;
            axi_rdata  <= bk_rdata;
            axi_rresp  <= RESP_OKAY;
          end else if (TO_EN && rcnt == TO_VAL) begin
            rd_state   <= RD_RESP;
            axi_rvalid <= 1'b1;
            axi_rdata  <= '0;
            axi_rresp  <= RESP_SLVERR;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        RD_RESP: begin
          if (axi_rready) begin
            rd_state    <= RD_IDLE;
            axi_rvalid  <= 1'b0;
            axi_arready <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axilite_slave_resp.sv
// ==== tb_axilite_slave_resp : scoreboard bench for axilite_slave_resp (TIMEOUT = 8) ====
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_axilite_slave_resp;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr, bk_waddr, bk_raddr;
  logic [DW-1:0] wdata, rdata, bk_wdata, bk_rdata;
  logic [SW-1:0] wstrb, bk_wstrb;
  logic [1:0] bresp, rresp;
  logic bk_wstart, bk_wdone, bk_rstart, bk_rdone;

  axilite_slave_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .axi_aclk(clk), .axi_aresetn(rstn),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp),
    .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
    .bk_wdone(bk_wdone), .bk_rstart(bk_rstart), .bk_raddr(bk_raddr),
    .bk_rdata(bk_rdata), .bk_rdone(bk_rdone)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb;} wcmd_t;
  typedef struct packed {logic [DW-1:0] data; logic [1:0] resp;} rrsp_t;

  wcmd_t         exp_wcmd[$];
  logic [1:0]    exp_bresp[$];
  logic [AW-1:0] exp_raddr[$];
  rrsp_t         exp_r[$];

  int tests = 0;
  int fails = 0;
  int wstart_cnt = 0;

  always @(posedge clk) if (bk_wstart === 1'b1) wstart_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*AW+2*DW+SW+12-1:0] all_outs();
    return {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
            bk_wstart, bk_waddr, bk_wdata, bk_wstrb, bk_rstart, bk_raddr};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    rstn = 1'b1;
    tests++;
    if ({awready, wready, arready} !== 3'b000) begin
      fails++; $display("FAIL reset_readies_low: got %b want 000", {awready, wready, arready});
    end
    tick();
    tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++; $display("FAIL readies_after_reset: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle();
    wcmd_t c;
    logic [1:0] eb;
    c.addr = 12'h010; c.data = 32'hDEADBEEF; c.strb = 4'hF;
    exp_wcmd.push_back(c); exp_bresp.push_back(2'b00);
    awvalid = 1'b1; awaddr = c.addr; wvalid = 1'b1; wdata = c.data; wstrb = c.strb;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    c = exp_wcmd.pop_front();
    tests++;
    if ({bk_wstart, bk_waddr, bk_wdata, bk_wstrb} !== {1'b1, c.addr, c.data, c.strb}) begin
      fails++; $display("FAIL same_cycle_bk: got %b %h %h %h want 1 %h %h %h",
                        bk_wstart, bk_waddr, bk_wdata, bk_wstrb, c.addr, c.data, c.strb);
    end
    tests++;
    if ({awready, wready} !== 2'b00) begin
      fails++; $display("FAIL same_cycle_readies_drop: got %b want 00", {awready, wready});
    end
    tick();
    tests++;
    if (bk_wstart !== 1'b0) begin
      fails++; $display("FAIL wstart_single_cycle: got %b want 0", bk_wstart);
    end
    tick();
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    eb = exp_bresp.pop_front();
    tests++;
    if ({bvalid, bresp} !== {1'b1, eb}) begin
      fails++; $display("FAIL same_cycle_bresp: got %b/%b want 1/%b", bvalid, bresp, eb);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    tests++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      fails++; $display("FAIL b_handshake_idle: got %b want 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_w_before_aw();
    wcmd_t c;
    logic [1:0] eb;
    int base;
    base = wstart_cnt;
    c.addr = 12'h020; c.data = 32'h12345678; c.strb = 4'hF;
    exp_wcmd.push_back(c); exp_bresp.push_back(2'b00);
    wvalid = 1'b1; wdata = c.data; wstrb = c.strb;
    tick();
    wvalid = 1'b0; wdata = '0;
    tests++;
    if ({wready, awready, bk_wstart} !== 3'b010) begin
      fails++; $display("FAIL w_first_readies: got %b want 010", {wready, awready, bk_wstart});
    end
    repeat (2) tick();
    awvalid = 1'b1; awaddr = c.addr;
    tick();
    awvalid = 1'b0; awaddr = '0;
    c = exp_wcmd.pop_front();
    tests++;
    if ({bk_wstart, bk_waddr, bk_wdata, bk_wstrb} !== {1'b1, c.addr, c.data, c.strb}) begin
      fails++; $display("FAIL w_first_bk: got %b %h %h %h want 1 %h %h %h",
                        bk_wstart, bk_waddr, bk_wdata, bk_wstrb, c.addr, c.data, c.strb);
    end
    tick();
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    eb = exp_bresp.pop_front();
    tests++;
    if ({bvalid, bresp} !== {1'b1, eb}) begin
      fails++; $display("FAIL min_latency_bvalid: got %b/%b want 1/%b", bvalid, bresp, eb);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    tests++;
    if (wstart_cnt - base != 1) begin
      fails++; $display("FAIL w_first_start_count: got %0d want 1", wstart_cnt - base);
    end
  endtask

  task automatic test_read_hold();
    rrsp_t r;
    logic [AW-1:0] ea;
    exp_raddr.push_back(12'h004);
    arvalid = 1'b1; araddr = 12'h004;
    tick();
    arvalid = 1'b0; araddr = '0;
    ea = exp_raddr.pop_front();
    tests++;
    if ({bk_rstart, bk_raddr, arready} !== {1'b1, ea, 1'b0}) begin
      fails++; $display("FAIL read_start: got %b %h %b want 1 %h 0", bk_rstart, bk_raddr, arready, ea);
    end
    tick();
    r.data = 32'hCAFEF00D; r.resp = 2'b00;
    exp_r.push_back(r);
    bk_rdone = 1'b1; bk_rdata = r.data;
    tick();
    bk_rdone = 1'b0; bk_rdata = 32'hFFFF0000;
    r = exp_r.pop_front();
    tests++;
    if ({rvalid, rdata, rresp} !== {1'b1, r.data, r.resp}) begin
      fails++; $display("FAIL read_data: got %b %h %b want 1 %h %b", rvalid, rdata, rresp, r.data, r.resp);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({rvalid, rdata, rresp} !== {1'b1, r.data, r.resp}) begin
        fails++; $display("FAIL read_hold_%0d: got %b %h %b want 1 %h %b", i, rvalid, rdata, rresp, r.data, r.resp);
      end
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tests++;
    if ({rvalid, arready} !== 2'b01) begin
      fails++; $display("FAIL read_handshake: got %b want 01", {rvalid, arready});
    end
  endtask

  task automatic test_timeout();
    rrsp_t r;
    logic [AW-1:0] ea;
    exp_raddr.push_back(12'h0A8);
    r.data = '0; r.resp = 2'b10;
    exp_r.push_back(r);
    arvalid = 1'b1; araddr = 12'h0A8;
    tick();
    arvalid = 1'b0;
    ea = exp_raddr.pop_front();
    tests++;
    if ({bk_rstart, bk_raddr} !== {1'b1, ea}) begin
      fails++; $display("FAIL to_start: got %b %h want 1 %h", bk_rstart, bk_raddr, ea);
    end
    repeat (TO) tick();
    tests++;
    if (rvalid !== 1'b0) begin
      fails++; $display("FAIL to_early: rvalid got %b want 0 at start+%0d", rvalid, TO);
    end
    tick();
    r = exp_r.pop_front();
    tests++;
    if ({rvalid, rdata, rresp} !== {1'b1, r.data, r.resp}) begin
      fails++; $display("FAIL to_slverr: got %b %h %b want 1 %h %b", rvalid, rdata, rresp, r.data, r.resp);
    end
    bk_rdone = 1'b1; bk_rdata = 32'h55AA55AA;
    tick();
    bk_rdone = 1'b0;
    tests++;
    if ({rvalid, rdata, rresp, bk_rstart} !== {1'b1, r.data, r.resp, 1'b0}) begin
      fails++; $display("FAIL to_late_done: got %b %h %b %b want 1 %h %b 0", rvalid, rdata, rresp, bk_rstart, r.data, r.resp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    bk_rdone = 1'b1;
    tick();
    bk_rdone = 1'b0;
    tick();
    tests++;
    if ({rvalid, arready, rdata} !== {1'b0, 1'b1, r.data}) begin
      fails++; $display("FAIL idle_done_ignored: got %b %b %h want 0 1 %h", rvalid, arready, rdata, r.data);
    end
  endtask

  task automatic test_timeout_tie();
    rrsp_t r;
    exp_raddr.push_back(12'h0FC);
    arvalid = 1'b1; araddr = 12'h0FC;
    tick();
    arvalid = 1'b0;
    void'(exp_raddr.pop_front());
    repeat (TO) tick();
    r.data = 32'h600DF00D; r.resp = 2'b00;
    exp_r.push_back(r);
    bk_rdone = 1'b1; bk_rdata = r.data;
    tick();
    bk_rdone = 1'b0;
    r = exp_r.pop_front();
    tests++;
    if ({rvalid, rdata, rresp} !== {1'b1, r.data, r.resp}) begin
      fails++; $display("FAIL tie_done_wins: got %b %h %b want 1 %h %b", rvalid, rdata, rresp, r.data, r.resp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_concurrent();
    wcmd_t c;
    rrsp_t r;
    logic [1:0] eb;
    logic [AW-1:0] ea;
    c.addr = 12'h3C0; c.data = 32'hA5A50F0F; c.strb = 4'h6;
    exp_wcmd.push_back(c); exp_bresp.push_back(2'b00); exp_raddr.push_back(12'h7FC);
    awvalid = 1'b1; awaddr = c.addr; wvalid = 1'b1; wdata = c.data; wstrb = c.strb;
    arvalid = 1'b1; araddr = 12'h7FC;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    c = exp_wcmd.pop_front();
    ea = exp_raddr.pop_front();
    tests++;
    if ({bk_wstart, bk_rstart, bk_waddr, bk_wdata, bk_wstrb, bk_raddr} !==
        {1'b1, 1'b1, c.addr, c.data, c.strb, ea}) begin
      fails++; $display("FAIL conc_starts: got %b%b %h %h %h %h want 11 %h %h %h %h",
                        bk_wstart, bk_rstart, bk_waddr, bk_wdata, bk_wstrb, bk_raddr, c.addr, c.data, c.strb, ea);
    end
    tick();
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    eb = exp_bresp.pop_front();
    tests++;
    if ({bvalid, bresp, rvalid} !== {1'b1, eb, 1'b0}) begin
      fails++; $display("FAIL conc_write_resp: got %b %b %b want 1 %b 0", bvalid, bresp, rvalid, eb);
    end
    r.data = 32'h0BADC0DE; r.resp = 2'b00;
    exp_r.push_back(r);
    bk_rdone = 1'b1; bk_rdata = r.data;
    bready = 1'b1;
    tick();
    bk_rdone = 1'b0; bready = 1'b0;
    r = exp_r.pop_front();
    tests++;
    if ({bvalid, rvalid, rdata, rresp} !== {1'b0, 1'b1, r.data, r.resp}) begin
      fails++; $display("FAIL conc_read_resp: got %b %b %h %b want 0 1 %h %b", bvalid, rvalid, rdata, rresp, r.data, r.resp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wcmd_t c;
    logic [1:0] eb;
    int bseen;
    c.addr = 12'h044; c.data = 32'h11112222; c.strb = 4'h3;
    exp_wcmd.push_back(c); exp_bresp.push_back(2'b00);
    awvalid = 1'b1; awaddr = c.addr; wvalid = 1'b1; wdata = c.data; wstrb = c.strb;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    void'(exp_wcmd.pop_front());
    tick();
    rstn = 1'b0;
    exp_bresp.delete();
    tick();
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL midreset_outputs: got %h want 0", all_outs());
    end
    bseen = 0;
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) bk_wdone = 1'b1;
      tick();
      bk_wdone = 1'b0;
      if (bvalid !== 1'b0) bseen++;
    end
    tests++;
    if (bseen != 0 || awready !== 1'b1) begin
      fails++; $display("FAIL midreset_no_bvalid: bvalid cycles got %0d want 0, awready %b want 1", bseen, awready);
    end
    c.addr = 12'h048; c.data = 32'h33334444; c.strb = 4'hC;
    exp_wcmd.push_back(c); exp_bresp.push_back(2'b00);
    awvalid = 1'b1; awaddr = c.addr; wvalid = 1'b1; wdata = c.data; wstrb = c.strb;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    c = exp_wcmd.pop_front();
    tests++;
    if ({bk_wstart, bk_waddr, bk_wdata, bk_wstrb} !== {1'b1, c.addr, c.data, c.strb}) begin
      fails++; $display("FAIL post_reset_bk: got %b %h %h %h want 1 %h %h %h",
                        bk_wstart, bk_waddr, bk_wdata, bk_wstrb, c.addr, c.data, c.strb);
    end
    tick();
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    eb = exp_bresp.pop_front();
    tests++;
    if ({bvalid, bresp} !== {1'b1, eb}) begin
      fails++; $display("FAIL post_reset_bresp: got %b/%b want 1/%b", bvalid, bresp, eb);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    bk_wdone = 1'b0; bk_rdone = 1'b0; bk_rdata = '0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_hold();
    test_timeout();
    test_timeout_tie();
    test_concurrent();
    test_reset_mid();
    tests++;
    if (exp_wcmd.size() + exp_bresp.size() + exp_raddr.size() + exp_r.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d pending want 0",
                        exp_wcmd.size() + exp_bresp.size() + exp_raddr.size() + exp_r.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
